module_key_entry: RTL

- Operand-entry controller sitting directly downstream of the keypad scan/debounce stage.
- Consumes one-cycle key events (key code 0x0–0xF), assembles up to DIGITS decimal digits per operand, and drives the 4-digit 7-segment display mux with the current entry.
- Key A latches operand A; key B latches operand B.
- Hands both operands to the next stage over a valid/ready handshake.

---
 rtl/module_key_entry.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/module_key_entry.sv
// module_key_entry: operand-entry controller behind the keypad debouncer.
// Gathers up to DIGITS decimal digits per operand. Key A latches operand A
// and key B latches operand B. The pair is then offered over a valid/ready
// handshake, and the current entry drives the 4-digit BCD display.
// Optional macro KEY_ENTRY_BACKSPACE_EN: key 0xD deletes the last digit.
//
// state     | meaning
// S_ENTER_A | collecting digits of operand A (reset state)
// S_ENTER_B | collecting digits of operand B
// S_HOLD    | pair offered downstream; keys ignored until handshake
module module_key_entry #(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             ops_valid,
  input  logic             ops_ready,
  output logic [15:0]      disp_bcd,
  output logic [3:0]       disp_blank,
  output logic             entry_sel
);

  typedef enum logic [1:0] {S_ENTER_A, S_ENTER_B, S_HOLD} state_t;

  localparam logic [2:0] L_DIGITS = 3'(DIGITS);

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_bcd, w_bcd_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_op_a, w_op_a_nxt;
  logic [WIDTH-1:0] r_op_b, w_op_b_nxt;
  logic             r_ops_valid, w_ops_valid_nxt;
  logic [3:0]       r_blank, w_blank_nxt;
  logic [WIDTH-1:0] w_bin;

  // Decimal value of the digits currently held in the shift register
  always_comb begin
    w_bin = WIDTH'(r_bcd[3:0])
          + WIDTH'(r_bcd[7:4])  * WIDTH'(10)
          + WIDTH'(r_bcd[11:8]) * WIDTH'(100);
    if (DIGITS == 4) begin
      w_bin = w_bin + WIDTH'(r_bcd[15:12]) * WIDTH'(1000);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_ENTER_A;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_ops_valid <= 1'b0;
      r_blank     <= 4'b1111;
    end else begin
      r_state     <= w_state_nxt;
      r_bcd       <= w_bcd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_op_a      <= w_op_a_nxt;
      r_op_b      <= w_op_b_nxt;
      r_ops_valid <= w_ops_valid_nxt;
      r_blank     <= w_blank_nxt;
    end
  end

  // Next-state and datapath decode of key events and the handshake
  always_comb begin
    w_state_nxt     = r_state;
    w_bcd_nxt       = r_bcd;
    w_cnt_nxt       = r_cnt;
    w_op_a_nxt      = r_op_a;
    w_op_b_nxt      = r_op_b;
    w_ops_valid_nxt = r_ops_valid;
    case (r_state)
      S_ENTER_A, S_ENTER_B: begin
        if (key_valid) begin
          case (key_code)
            4'hA: begin
              if (r_state == S_ENTER_A && r_cnt != 3'd0) begin
                w_op_a_nxt  = w_bin;
                w_bcd_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_ENTER_B;
              end
            end
            4'hB: begin
              // Digits stay in place so the display keeps showing operand B
              if (r_state == S_ENTER_B && r_cnt != 3'd0) begin
                w_op_b_nxt      = w_bin;
                w_ops_valid_nxt = 1'b1;
                w_state_nxt     = S_HOLD;
              end
            end
            4'hC: begin
              w_bcd_nxt = '0;
              w_cnt_nxt = '0;
            end
`ifdef KEY_ENTRY_BACKSPACE_EN
            4'hD: begin
              if (r_cnt != 3'd0) begin
                w_bcd_nxt = {4'h0, r_bcd[15:4]};
                w_cnt_nxt = r_cnt - 3'd1;
              end
            end
`endif
            default: begin
              // Digits beyond DIGITS are dropped rather than wrapping
              if (key_code <= 4'h9 && r_cnt < L_DIGITS) begin
                w_bcd_nxt = {r_bcd[11:0], key_code};
                w_cnt_nxt = r_cnt + 3'd1;
              end
            end
          endcase
        end
      end
      S_HOLD: begin
        if (r_ops_valid && ops_ready) begin
          w_ops_valid_nxt = 1'b0;
          w_bcd_nxt       = '0;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_ENTER_A;
        end
      end
      default: w_state_nxt = S_ENTER_A;
    endcase
    for (int i = 0; i < 4; i++) begin
      w_blank_nxt[i] = (3'(i) >= w_cnt_nxt);
    end
  end

  // Outputs driven straight from registers
  always_comb begin
    op_a       = r_op_a;
    op_b       = r_op_b;
    ops_valid  = r_ops_valid;
    disp_bcd   = r_bcd;
    disp_blank = r_blank;
    entry_sel  = (r_state != S_ENTER_A);
  end

endmodule
